inst_encoder: RTL and testbench
===============================

# inst_encoder

Packs RISC-V RV32I instruction fields and a signed immediate into a 32-bit instruction word. This is the inverse of the hart's field/immediate decoder. It sits in the test/boot path: a program-loader or self-test sequencer streams field tuples in, and the block emits encoded words with sequential byte addresses toward instruction memory. A 2-entry output buffer keeps both handshakes fully registered.

## Interface
- ADDR_W, 32: width of the output byte-address counter
- BASE_ADDR, 0: address given to the first word after reset or restart
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_in_valid  in  1  field tuple present
- o_in_ready  out  1  block can accept a tuple this cycle
- i_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- i_opcode  in  7  opcode, placed in bits [6:0]
- i_funct3  in  3  placed in bits [14:12] (not used for U/J)
- i_funct7  in  7  placed in bits [31:25] (R only)
- i_rd, i_rs1, i_rs2  in  5 each  register fields, placed per format
- i_imm  in  32  signed immediate value; for U this is the full value, with imm[31:12] used
- i_restart  in  1  reload the address counter to BASE_ADDR
- o_out_valid  out  1  encoded word available
- i_out_ready  in  1  consumer takes the word
- o_inst  out  32  encoded instruction
- o_addr  out  ADDR_W  byte address of o_inst
- o_bad  out  1  this word failed the immediate/format check
- o_err_seen  out  1  sticky: some word failed since the last reset or restart

## Operation
- A tuple is accepted when i_in_valid && o_in_ready. It is encoded combinationally and written into the 2-entry FIFO together with its address and bad flag.
- Packing per format:
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Illegal i_fmt: o_inst = 0.
- Address counter:
  - Each accepted word takes the current counter value.
  - The counter then advances by 4 and wraps modulo 2^ADDR_W.
- i_restart in the same cycle as an accept: restart wins. The word gets BASE_ADDR and the counter becomes BASE_ADDR+4. Restart also clears o_err_seen.
- Restart does not flush the FIFO. Words already buffered keep their addresses.
- FIFO: count 0..2; o_in_ready = (count != 2) && !i_rst. Simultaneous push and pop at count 2 is not possible because o_in_ready is 0 at count 2.
- Words are emitted strictly in acceptance order.

## Timing
- Reset values: FIFO empty, o_out_valid=0, o_inst=0, o_addr=0, o_bad=0, o_err_seen=0, counter=BASE_ADDR. o_in_ready is 1 on the first cycle after i_rst deasserts.
- Reset mid-operation drops buffered words. o_out_valid is 0 on the cycle after the reset edge.
- Latency: a tuple accepted at edge N appears on o_out_valid/o_inst after edge N (next cycle).
- Throughput: one word per cycle while i_out_ready=1.
- o_inst, o_addr and o_bad are stable while o_out_valid && !i_out_ready.
- o_in_ready, o_out_valid and all data outputs are driven from registers. No combinational ready path.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: o_bad=1 when any of the following holds. o_err_seen sets on the cycle the bad word is accepted.
  - I/S immediate outside [-2048, 2047]
  - B immediate outside [-4096, 4094] or odd
  - J immediate outside [-1048576, 1048574] or odd
  - U with imm[11:0] != 0
  - illegal i_fmt
- Undefined: o_bad and o_err_seen are tied 0. Out-of-range bits are silently truncated. Illegal i_fmt still yields 0.

## Structure
- Shared package riscv_pkg holds:
  - the FMT_R..FMT_J encodings
  - the opcode constants (OP_IMM, STORE, BRANCH, LUI, JAL, ...)
  - the immediate range limits
- Sub-module inst_pack: purely combinational fields-to-word packing plus the range check.
- The top level holds the FIFO, the address counter and the sticky flag.

## Test plan
- addi x1,x0,5 (fmt=1, op=0x13, rd=1, f3=0, imm=5) after reset -> o_inst=0x00500093, o_addr=BASE_ADDR, o_bad=0, one cycle after accept.
- sw x2,8(x1) (fmt=2, op=0x23, f3=2, rs1=1, rs2=2, imm=8) -> o_inst=0x0020A423.
- beq x0,x0,-4 (fmt=3, op=0x63, imm=0xFFFFFFFC) -> o_inst=0xFE000EE3.
- Backpressure: i_out_ready=0, three back-to-back tuples -> two accepted, o_in_ready=0, third stalls. On release, words emerge in order at addresses BASE, +4, +8.
- Range check: I imm=2048, then B imm=3 -> o_bad=1 on both and o_err_seen=1. i_restart -> o_err_seen=0 and the next word is at BASE_ADDR. Without the macro, o_bad stays 0.
- i_rst asserted with 2 words buffered -> o_out_valid=0 next cycle. The next accepted word is at BASE_ADDR.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I encoding constants shared by the instruction encoder: format codes, major opcodes
// and the immediate ranges each format can represent.
package riscv_pkg;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpOp     = 7'h33;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpJal    = 7'h6f;

  localparam int ImmIMin = -2048;
  localparam int ImmIMax = 2047;
  localparam int ImmBMin = -4096;
  localparam int ImmBMax = 4094;
  localparam int ImmJMin = -1048576;
  localparam int ImmJMax = 1048574;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    int v;
    v = $signed(imm);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-tuple input and encoded-word output handshakes of inst_encoder.
// The slave modport is the encoder's view; master is the loader/consumer view.
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_in_valid;
  logic              o_in_ready;
  logic [2:0]        i_fmt;
  logic [6:0]        i_opcode;
  logic [2:0]        i_funct3;
  logic [6:0]        i_funct7;
  logic [4:0]        i_rd;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [31:0]       i_imm;
  logic              i_restart;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [31:0]       o_inst;
  logic [ADDR_W-1:0] o_addr;
  logic              o_bad;
  logic              o_err_seen;

  modport slave (
    input  i_in_valid, i_fmt, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm,
    input  i_restart, i_out_ready,
    output o_in_ready, o_out_valid, o_inst, o_addr, o_bad, o_err_seen
  );

  modport master (
    output i_in_valid, i_fmt, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm,
    output i_restart, i_out_ready,
    input  o_in_ready, o_out_valid, o_inst, o_addr, o_bad, o_err_seen
  );
endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I field/immediate packer. With ENCODER_RANGE_CHECK_EN defined it also
// flags immediates the selected format cannot represent, and illegal formats.
module inst_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        bad_o
);

  always_comb begin
    inst_o = '0;
    case (fmt_e'(fmt_i))
      FmtR: inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FmtI: inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FmtS: inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FmtB: inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                      opcode_i};
      FmtU: inst_o = {imm_i[31:12], rd_i, opcode_i};
      FmtJ: inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: inst_o = '0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  always_comb begin
    bad_o = 1'b0;
    case (fmt_e'(fmt_i))
      FmtR:       bad_o = 1'b0;
      FmtI, FmtS: bad_o = !imm_in_range(imm_i, ImmIMin, ImmIMax);
      FmtB:       bad_o = !imm_in_range(imm_i, ImmBMin, ImmBMax) || imm_i[0];
      FmtU:       bad_o = (imm_i[11:0] != 12'd0);
      FmtJ:       bad_o = !imm_in_range(imm_i, ImmJMin, ImmJMax) || imm_i[0];
      default:    bad_o = 1'b1;
    endcase
  end
`else
  assign bad_o = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs accepted field tuples, tags them with sequential byte
// addresses and buffers them in a 2-entry registered FIFO. Range check: ENCODER_RANGE_CHECK_EN.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  inst_encoder_if.slave  bus
);

  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
    logic              bad;
  } entry_t;

  logic [31:0]       pack_inst;
  logic              pack_bad;
  logic              push, pop;
  logic [ADDR_W-1:0] word_addr;
  entry_t            new_entry;

  // head_q is the output register; tail_q holds the second word only while count_q == 2
  entry_t            head_q, head_d, tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              out_valid_q, in_ready_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  inst_pack u_pack (
    .fmt_i    (bus.i_fmt),
    .opcode_i (bus.i_opcode),
    .funct3_i (bus.i_funct3),
    .funct7_i (bus.i_funct7),
    .rd_i     (bus.i_rd),
    .rs1_i    (bus.i_rs1),
    .rs2_i    (bus.i_rs2),
    .imm_i    (bus.i_imm),
    .inst_o   (pack_inst),
    .bad_o    (pack_bad)
  );

  assign push      = bus.i_in_valid && bus.o_in_ready;
  assign pop       = out_valid_q && bus.i_out_ready;
  assign word_addr = bus.i_restart ? BASE_ADDR : addr_q;
  assign new_entry = '{inst: pack_inst, addr: word_addr, bad: pack_bad};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop && (count_q == 2'd2)) begin
      head_d  = tail_q;
      count_d = 2'd1;
    end else if (push && pop) begin
      head_d = new_entry;
    end else if (push) begin
      if (count_q == 2'd0) head_d = new_entry;
      else                 tail_d = new_entry;
      count_d = count_q + 2'd1;
    end else if (pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (push)               addr_d = word_addr + ADDR_W'(4);
    else if (bus.i_restart) addr_d = BASE_ADDR;
  end

  // A bad word accepted alongside a restart belongs to the new run, so it still sets the flag
  assign err_d = (bus.i_restart ? 1'b0 : err_q) | (push & pack_bad);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= (count_d != 2'd0);
      in_ready_q  <= (count_d != 2'd2);
      addr_q      <= addr_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_in_ready  = in_ready_q && !i_rst;
  assign bus.o_out_valid = out_valid_q;
  assign bus.o_inst      = head_q.inst;
  assign bus.o_addr      = head_q.addr;
  assign bus.o_bad       = head_q.bad;
  assign bus.o_err_seen  = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded RV32I words, address sequencing,
// backpressure, restart, range flags and mid-run reset.
module tb_inst_encoder;
  import riscv_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;
`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  inst_encoder #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    bus.i_fmt    = fmt;
    bus.i_opcode = op;
    bus.i_funct3 = f3;
    bus.i_funct7 = f7;
    bus.i_rd     = rd;
    bus.i_rs1    = rs1;
    bus.i_rs2    = rs2;
    bus.i_imm    = imm;
  endtask

  // Called just after a rising edge with i_out_ready=1 and the FIFO empty.
  task automatic send_chk(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic restart, input logic [31:0] exp_inst,
                          input logic exp_bad);
    logic [31:0] a;
    set_fields(fmt, op, f3, f7, rd, rs1, rs2, imm);
    bus.i_in_valid = 1'b1;
    bus.i_restart  = restart;
    check({tag, ".in_ready"}, {31'd0, bus.o_in_ready}, 32'd1);
    step();
    bus.i_in_valid = 1'b0;
    bus.i_restart  = 1'b0;
    a = restart ? BASE : exp_addr;
    @(negedge clk);
    check({tag, ".valid"}, {31'd0, bus.o_out_valid}, 32'd1);
    check({tag, ".inst"}, bus.o_inst, exp_inst);
    check({tag, ".addr"}, bus.o_addr, a);
    check({tag, ".bad"}, {31'd0, bus.o_bad}, {31'd0, exp_bad});
    exp_addr = a + 32'd4;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    bus.i_in_valid  = 1'b0;
    bus.i_restart   = 1'b0;
    bus.i_out_ready = 1'b1;
    set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    exp_addr = BASE;

    step();
    @(negedge clk);
    check("rst.valid", {31'd0, bus.o_out_valid}, 32'd0);
    check("rst.in_ready_low", {31'd0, bus.o_in_ready}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst.in_ready", {31'd0, bus.o_in_ready}, 32'd1);
    check("rst.inst", bus.o_inst, 32'd0);
    check("rst.addr", bus.o_addr, 32'd0);
    check("rst.bad", {31'd0, bus.o_bad}, 32'd0);
    check("rst.err", {31'd0, bus.o_err_seen}, 32'd0);
    step();

    // Formats, sequential addresses from BASE
    send_chk("addi", 3'd1, OpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093, 0);
    send_chk("sw", 3'd2, OpStore, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020_A423, 0);
    send_chk("beq", 3'd3, OpBranch, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0,
             32'hFE00_0EE3, 0);
    send_chk("add", 3'd0, OpOp, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3, 0);
    send_chk("lui", 3'd4, OpLui, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0,
             32'h1234_52B7, 0);
    send_chk("jal_pos", 3'd5, OpJal, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0,
             32'h0010_00EF, 0);
    send_chk("jal_neg", 3'd5, OpJal, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFE, 1'b0,
             32'hFFFF_F06F, 0);
    check("err.clean", {31'd0, bus.o_err_seen}, 32'd0);

    // Range check and sticky error
    send_chk("i_2048", 3'd1, OpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0,
             32'h8000_0093, RC);
    check("err.after_i", {31'd0, bus.o_err_seen}, {31'd0, RC});
    send_chk("b_odd", 3'd3, OpBranch, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0,
             32'h0000_0163, RC);
    check("err.after_b", {31'd0, bus.o_err_seen}, {31'd0, RC});
    bus.i_restart = 1'b1;
    step();
    bus.i_restart = 1'b0;
    exp_addr = BASE;
    @(negedge clk);
    check("err.restart", {31'd0, bus.o_err_seen}, 32'd0);
    step();
    send_chk("after_rs", 3'd1, OpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0,
             32'h0050_0093, 0);
    send_chk("illegal", 3'd6, OpImm, 3'd7, 7'h7f, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 1'b0,
             32'h0000_0000, RC);
    check("err.illegal", {31'd0, bus.o_err_seen}, {31'd0, RC});
    // Restart coincident with accept: word at BASE, next at BASE+4
    send_chk("rs_acc", 3'd1, OpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1,
             32'h0050_0093, 0);
    check("err.rs_acc", {31'd0, bus.o_err_seen}, 32'd0);
    send_chk("rs_next", 3'd2, OpStore, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0,
             32'h0020_A423, 0);

    // Backpressure: three back-to-back tuples, two accepted
    bus.i_restart = 1'b1;
    step();
    bus.i_restart   = 1'b0;
    bus.i_out_ready = 1'b0;
    bus.i_in_valid  = 1'b1;
    set_fields(3'd1, OpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    step();
    set_fields(3'd1, OpImm, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    step();
    set_fields(3'd1, OpImm, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
    @(negedge clk);
    check("bp.full_ready", {31'd0, bus.o_in_ready}, 32'd0);
    check("bp.inst0", bus.o_inst, 32'h0010_0093);
    step();
    @(negedge clk);
    check("bp.stall_ready", {31'd0, bus.o_in_ready}, 32'd0);
    check("bp.hold_inst", bus.o_inst, 32'h0010_0093);
    check("bp.hold_addr", bus.o_addr, BASE);
    step();
    bus.i_out_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp.inst1", bus.o_inst, 32'h0020_0113);
    check("bp.addr1", bus.o_addr, BASE + 32'd4);
    step();
    bus.i_in_valid = 1'b0;
    @(negedge clk);
    check("bp.valid2", {31'd0, bus.o_out_valid}, 32'd1);
    check("bp.inst2", bus.o_inst, 32'h0030_0193);
    check("bp.addr2", bus.o_addr, BASE + 32'd8);
    step();
    @(negedge clk);
    check("bp.drained", {31'd0, bus.o_out_valid}, 32'd0);
    step();

    // Reset with two words buffered
    bus.i_out_ready = 1'b0;
    bus.i_in_valid  = 1'b1;
    set_fields(3'd1, OpImm, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4);
    step();
    step();
    bus.i_in_valid = 1'b0;
    @(negedge clk);
    check("mr.buffered", {31'd0, bus.o_out_valid}, 32'd1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mr.valid", {31'd0, bus.o_out_valid}, 32'd0);
    step();
    rst             = 1'b0;
    bus.i_out_ready = 1'b1;
    exp_addr        = BASE;
    @(negedge clk);
    check("mr.in_ready", {31'd0, bus.o_in_ready}, 32'd1);
    step();
    send_chk("mr.first", 3'd1, OpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0,
             32'h0050_0093, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
